mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory port between an instruction-fetch port and a
// data port. It checks address legality, enforces an acknowledge timeout and keeps a sticky
// bus-error flag.
module mem_bus_arbiter #(
    parameter logic [31:0] MEM_TOP = 32'h0000_FFFF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busErr,
    output logic [31:0] errAddr
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;  // 1 = data port owns/served last
    logic        i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic        i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        m_req_q, m_req_d, m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        pick_data;
    logic [31:0] gnt_addr;
    logic        gnt_illegal;
    logic        resp_en;
    logic [31:0] resp_data;
    logic        err_en;
    logic [31:0] err_at;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_be_d     = m_be_q;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        resp_en    = 1'b0;
        resp_data  = 32'h0;
        err_en     = 1'b0;
        err_at     = m_addr_q;

        // Data wins a tie unless it was served last.
        pick_data   = d_req && !(i_req && owner_q);
        gnt_addr    = pick_data ? d_addr : i_addr;
        gnt_illegal = (gnt_addr > MEM_TOP) || (gnt_addr[1:0] != 2'b00);

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d   = pick_data;
                    i_gnt_d   = !pick_data;
                    d_gnt_d   = pick_data;
                    m_addr_d  = gnt_addr;
                    m_we_d    = pick_data && d_we;
                    m_wdata_d = pick_data ? d_wdata : 32'h0;
                    m_be_d    = pick_data ? d_be : 4'hF;
                    if (gnt_illegal) begin
                        state_d = StResp;
                        err_en  = 1'b1;
                        err_at  = gnt_addr;
                    end else begin
                        state_d = StBusy;
                        m_req_d = 1'b1;
                        cnt_d   = 8'h0;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 8'h1;
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    resp_en   = 1'b1;
                    resp_data = m_rdata;
                    state_d   = StIdle;
                end else if (cnt_q == CntLast) begin
                    m_req_d = 1'b0;
                    resp_en = 1'b1;
                    err_en  = 1'b1;
                    state_d = StIdle;
                end
            end
            StResp: begin
                resp_en = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (resp_en) begin
            if (owner_q) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = resp_data;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = resp_data;
            end
        end

        // Only the first error address is retained until reset.
        if (err_en) begin
            bus_err_d = 1'b1;
            if (!bus_err_q) begin
                err_addr_d = err_at;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'h0;
            owner_q    <= 1'b0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            m_be_q     <= 4'h0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_be_q     <= m_be_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_be     = m_be_q;
    assign busErr   = bus_err_q;
    assign errAddr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: requesters and a memory responder driven by $urandom,
// checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam logic [31:0] MemTop  = 32'h0000_FFFF;
    localparam int          Timeout = 16;
    localparam int          NumCycles = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busErr;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, errAddr;
    logic [3:0]  m_be;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .MEM_TOP (MemTop),
        .TIMEOUT (Timeout)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .busErr   (busErr),
        .errAddr  (errAddr)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle.
    logic        e_i_gnt, e_d_gnt, e_i_rvalid, e_d_rvalid, e_m_req, e_m_we, e_bus_err;
    logic [31:0] e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata, e_err_addr;
    logic [3:0]  e_m_be;

    // Transaction in flight: age < 0 means the arbiter is free to sample requests.
    int          age;
    logic        t_data, t_legal, last_data;
    int          ack_pct;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_addr();
        int sel = $urandom_range(0, 9);
        if (sel < 8) return {16'h0, 16'($urandom_range(0, 32'h3FFF)), 2'b00} >> 2 << 2;
        if (sel == 8) return MemTop + 32'd1 + 32'($urandom_range(0, 255)) * 4;
        return (32'($urandom_range(0, 32'h3FFF)) << 2) | 32'($urandom_range(1, 3));
    endfunction

    task automatic model_reset();
        {e_i_gnt, e_d_gnt, e_i_rvalid, e_d_rvalid, e_m_req, e_m_we, e_bus_err} = '0;
        {e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata, e_err_addr} = '0;
        e_m_be    = 4'h0;
        age       = -1;
        last_data = 1'b0;
    endtask

    task automatic respond(input logic [31:0] v);
        if (t_data) begin
            e_d_rvalid = 1'b1;
            e_d_rdata  = v;
        end else begin
            e_i_rvalid = 1'b1;
            e_i_rdata  = v;
        end
    endtask

    task automatic flag_error(input logic [31:0] a);
        if (!e_bus_err) e_err_addr = a;
        e_bus_err = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] a;
        e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rvalid = 1'b0; e_d_rvalid = 1'b0;
        if (rst) begin
            model_reset();
        end else if (age < 0) begin
            if (i_req || d_req) begin
                t_data    = d_req && !(i_req && last_data);
                last_data = t_data;
                a         = t_data ? d_addr : i_addr;
                e_i_gnt   = !t_data;
                e_d_gnt   = t_data;
                e_m_addr  = a;
                e_m_we    = t_data && d_we;
                e_m_wdata = t_data ? d_wdata : 32'h0;
                e_m_be    = t_data ? d_be : 4'hF;
                t_legal   = (a <= MemTop) && (a % 4 == 0);
                if (t_legal) begin
                    e_m_req = 1'b1;
                    age     = 1;
                end else begin
                    flag_error(a);
                    age = 0;
                end
            end
        end else if (!t_legal) begin
            respond(32'h0);
            age = -1;
        end else if (m_ack) begin
            respond(m_rdata);
            e_m_req = 1'b0;
            age     = -1;
        end else if (age == Timeout) begin
            respond(32'h0);
            flag_error(e_m_addr);
            e_m_req = 1'b0;
            age     = -1;
        end else begin
            age++;
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; m_rdata = 0;
        ack_pct = 100;
        model_reset();
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < NumCycles; cyc++) begin
            @(negedge clk);
            check_val("i_gnt", 32'(i_gnt), 32'(e_i_gnt));
            check_val("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
            check_val("i_rvalid", 32'(i_rvalid), 32'(e_i_rvalid));
            check_val("d_rvalid", 32'(d_rvalid), 32'(e_d_rvalid));
            check_val("i_rdata", i_rdata, e_i_rdata);
            check_val("d_rdata", d_rdata, e_d_rdata);
            check_val("m_req", 32'(m_req), 32'(e_m_req));
            check_val("busErr", 32'(busErr), 32'(e_bus_err));
            check_val("errAddr", errAddr, e_err_addr);
            if (e_m_req) begin
                check_val("m_addr", m_addr, e_m_addr);
                check_val("m_we", 32'(m_we), 32'(e_m_we));
                check_val("m_be", 32'(m_be), 32'(e_m_be));
                if (t_data) check_val("m_wdata", m_wdata, e_m_wdata);
            end

            // Requesters: drop after grant, occasionally abandon, randomly issue new requests.
            if (e_i_gnt) i_req = 1'b0;
            if (!i_req && $urandom_range(0, 99) < 30) begin
                i_req  = 1'b1;
                i_addr = gen_addr();
            end else if (i_req && !e_i_gnt && $urandom_range(0, 99) < 3) begin
                i_req = 1'b0;
            end
            if (e_d_gnt) d_req = 1'b0;
            if (!d_req && $urandom_range(0, 99) < 30) begin
                d_req   = 1'b1;
                d_addr  = gen_addr();
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom();
                d_be    = 4'($urandom_range(0, 15));
            end else if (d_req && !e_d_gnt && $urandom_range(0, 99) < 3) begin
                d_req = 1'b0;
            end

            // Memory: per-transaction ack rate, including never; stray acks when idle.
            if (e_i_gnt || e_d_gnt) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 0;
                    1: ack_pct = 10;
                    2: ack_pct = 40;
                    default: ack_pct = 100;
                endcase
            end
            m_rdata = $urandom();
            if (e_m_req) m_ack = ($urandom_range(0, 99) < ack_pct);
            else         m_ack = ($urandom_range(0, 9) == 0);

            rst = (cyc < 2) || ($urandom_range(0, 199) == 0);
            model_step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
